// File: rtl/dct2_4_pipe_if.sv
// ============================================================================
// Module      : dct2_4_pipe_if
// Description : Vector-in / vector-out valid-ready bundle for the 4-point DCT core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dct2_4_pipe_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_inv;
    logic signed [IN_W-1:0]  in_x [0:3];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_y [0:3];
    logic                    out_sat;
    logic [15:0]             sat_cnt;

    modport master (
        output in_valid, in_inv, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_sat, sat_cnt
    );

    modport slave (
        input  in_valid, in_inv, in_x, out_ready,
        output in_ready, out_valid, out_y, out_sat, sat_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dct2_4_pipe.sv
// ============================================================================
// Module      : dct2_4_pipe
// Description : 3-stage forward/inverse 4-point DCT-II with round/shift/saturate.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dct2_4_pipe #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SHIFT = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dct2_4_pipe_if.slave bus
);

    localparam int ACC_W   = IN_W + 9;
    localparam int BF_W    = IN_W + 1;
    localparam int RND_W   = ACC_W + 1;
    localparam int RND_INT = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
    localparam logic signed [RND_W-1:0] RND_OFS = RND_W'(RND_INT);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic signed [ACC_W-1:0] mul83(input logic signed [ACC_W-1:0] a);
        return (a <<< 6) + (a <<< 4) + (a <<< 1) + a;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul36(input logic signed [ACC_W-1:0] a);
        return (a <<< 5) + (a <<< 2);
    endfunction

    // ------------------------------------------------------------------------
    // Stage registers and flow control
    // ------------------------------------------------------------------------
    logic                    v1_q, v1_d, inv1_q, inv1_d;
    logic signed [BF_W-1:0]  p1_q [0:3];
    logic signed [BF_W-1:0]  p1_d [0:3];
    logic                    v2_q, v2_d;
    logic signed [ACC_W-1:0] a2_q [0:3];
    logic signed [ACC_W-1:0] a2_d [0:3];
    logic                    v3_q, v3_d, sat3_q, sat3_d;
    logic signed [OUT_W-1:0] y3_q [0:3];
    logic signed [OUT_W-1:0] y3_d [0:3];
    logic [15:0]             cnt_q, cnt_d;

    logic w_ready1, w_ready2, w_ready3;

    assign w_ready3 = !v3_q || bus.out_ready;
    assign w_ready2 = !v2_q || w_ready3;
    assign w_ready1 = !v1_q || w_ready2;

    // ------------------------------------------------------------------------
    // Stage 1: forward butterfly, or operand reordering for the inverse
    // ------------------------------------------------------------------------
    logic signed [BF_W-1:0] w_xe [0:3];
    logic signed [BF_W-1:0] w_bf [0:3];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_xe[i] = BF_W'(bus.in_x[i]);
        end
        if (bus.in_inv) begin
            // Inverse: even pair (y0,y2) feeds the 64-taps, odd pair (y1,y3) the 83/36-taps
            w_bf[0] = w_xe[0];
            w_bf[1] = w_xe[2];
            w_bf[2] = w_xe[1];
            w_bf[3] = w_xe[3];
        end else begin
            w_bf[0] = w_xe[0] + w_xe[3];
            w_bf[1] = w_xe[1] + w_xe[2];
            w_bf[2] = w_xe[0] - w_xe[3];
            w_bf[3] = w_xe[1] - w_xe[2];
        end

        v1_d   = v1_q;
        inv1_d = inv1_q;
        p1_d   = p1_q;
        if (w_ready1) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                inv1_d = bus.in_inv;
                p1_d   = w_bf;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: shared 64/83/36 multiplies, then output recombination
    // ------------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_pa [0:3];
    logic signed [ACC_W-1:0] w_e0, w_e1, w_o0, w_o1;
    logic signed [ACC_W-1:0] w_res [0:3];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pa[i] = ACC_W'(p1_q[i]);
        end
        w_e0 = (w_pa[0] + w_pa[1]) <<< 6;
        w_e1 = (w_pa[0] - w_pa[1]) <<< 6;
        w_o0 = mul83(w_pa[2]) + mul36(w_pa[3]);
        w_o1 = mul36(w_pa[2]) - mul83(w_pa[3]);

        if (inv1_q) begin
            w_res[0] = w_e0 + w_o0;
            w_res[1] = w_e1 + w_o1;
            w_res[2] = w_e1 - w_o1;
            w_res[3] = w_e0 - w_o0;
        end else begin
            w_res[0] = w_e0;
            w_res[1] = w_o0;
            w_res[2] = w_e1;
            w_res[3] = w_o1;
        end

        v2_d = v2_q;
        a2_d = a2_q;
        if (w_ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                a2_d = w_res;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: round (floor after offset), shift and clamp each lane
    // ------------------------------------------------------------------------
    logic signed [OUT_W-1:0] w_lane_y [0:3];
    logic [3:0]              w_lane_sat;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic signed [RND_W-1:0] w_t;

        assign w_t = (RND_W'(a2_q[l]) + RND_OFS) >>> SHIFT;

        if (OUT_W < RND_W) begin : g_clamp
            localparam logic signed [RND_W-1:0] MAX_V = RND_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
            localparam logic signed [RND_W-1:0] MIN_V = ~MAX_V;
            logic w_hi, w_lo;

            assign w_hi          = (w_t > MAX_V);
            assign w_lo          = (w_t < MIN_V);
            assign w_lane_y[l]   = w_hi ? OUT_W'(MAX_V) :
                                   w_lo ? OUT_W'(MIN_V) : w_t[OUT_W-1:0];
            assign w_lane_sat[l] = w_hi || w_lo;
        end else begin : g_wide
            assign w_lane_y[l]   = OUT_W'(w_t);
            assign w_lane_sat[l] = 1'b0;
        end
    end

    always_comb begin
        v3_d   = v3_q;
        y3_d   = y3_q;
        sat3_d = sat3_q;
        if (w_ready3) begin
            v3_d = v2_q;
            if (v2_q) begin
                y3_d   = w_lane_y;
                sat3_d = |w_lane_sat;
            end
        end

        cnt_d = cnt_q;
        if (v3_q && bus.out_ready && sat3_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            inv1_q <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sat3_q <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                p1_q[i] <= '0;
                a2_q[i] <= '0;
                y3_q[i] <= '0;
            end
        end else begin
            v1_q   <= v1_d;
            inv1_q <= inv1_d;
            p1_q   <= p1_d;
            v2_q   <= v2_d;
            a2_q   <= a2_d;
            v3_q   <= v3_d;
            y3_q   <= y3_d;
            sat3_q <= sat3_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_ready  = w_ready1;
    assign bus.out_valid = v3_q;
    assign bus.out_y     = y3_q;
    assign bus.out_sat   = sat3_q;
    assign bus.sat_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dct2_4_pipe.sv
// ============================================================================
// Module      : tb_dct2_4_pipe
// Description : Directed self-checking bench for the 4-point DCT pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dct2_4_pipe;

    localparam int IN_W  = 12;
    localparam int OUT_W = 16;
    localparam int SHIFT = 2;

    typedef struct packed {
        logic        sat;
        logic [15:0] y0;
        logic [15:0] y1;
        logic [15:0] y2;
        logic [15:0] y3;
    } exp_t;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt;

    dct2_4_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct2_4_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden model written directly from the transform equations
    function automatic exp_t model(input int a0, input int a1, input int a2, input int a3, input bit inv);
        int   v [4];
        int   r [4];
        int   e0, e1, o0, o1;
        exp_t e;
        if (!inv) begin
            v[0] = 64 * (a0 + a1 + a2 + a3);
            v[2] = 64 * ((a0 + a3) - (a1 + a2));
            v[1] = 83 * (a0 - a3) + 36 * (a1 - a2);
            v[3] = 36 * (a0 - a3) - 83 * (a1 - a2);
        end else begin
            e0 = 64 * (a0 + a2);
            e1 = 64 * (a0 - a2);
            o0 = 83 * a1 + 36 * a3;
            o1 = 36 * a1 - 83 * a3;
            v[0] = e0 + o0;
            v[1] = e1 + o1;
            v[2] = e1 - o1;
            v[3] = e0 - o0;
        end
        e.sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r[i] = (v[i] + (1 << (SHIFT - 1))) >>> SHIFT;
            if (r[i] > 32767) begin
                r[i] = 32767;
                e.sat = 1'b1;
            end else if (r[i] < -32768) begin
                r[i] = -32768;
                e.sat = 1'b1;
            end
        end
        e.y0 = r[0][15:0];
        e.y1 = r[1][15:0];
        e.y2 = r[2][15:0];
        e.y3 = r[3][15:0];
        return e;
    endfunction

    // One vector through an idle pipeline, checking latency, values and sat_cnt
    task automatic send_dir(input string tag, input int a0, input int a1, input int a2, input int a3,
                            input bit inv, input int e0, input int e1, input int e2, input int e3,
                            input bit es, input int cnt_after);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inv    = inv;
        bus.in_x[0]   = IN_W'(a0);
        bus.in_x[1]   = IN_W'(a1);
        bus.in_x[2]   = IN_W'(a2);
        bus.in_x[3]   = IN_W'(a3);
        #1 check({tag, " in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, " valid@N+1"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, " valid@N+2"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, " valid@N+3"}, bus.out_valid, 1);
        check({tag, " y0"}, bus.out_y[0], e0);
        check({tag, " y1"}, bus.out_y[1], e1);
        check({tag, " y2"}, bus.out_y[2], e2);
        check({tag, " y3"}, bus.out_y[3], e3);
        check({tag, " sat"}, bus.out_sat, es);
        check({tag, " cnt_pre"}, bus.sat_cnt, cnt_after - int'(es));
        @(negedge clk);
        check({tag, " cnt_post"}, bus.sat_cnt, cnt_after);
        check({tag, " drained"}, bus.out_valid, 0);
    endtask

    int   sx [8][4] = '{'{100, -50, 25, -7}, '{-2048, 2047, -2048, 2047}, '{64, 32, -16, 8},
                        '{2047, -2048, 2047, -2048}, '{0, 0, 0, 0}, '{-1, -1, -1, -1},
                        '{500, -300, 200, -100}, '{-3, 5, -7, 9}};
    bit   sinv [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        exp_t e;
        exp_t q [$];
        exp_t saved;
        int   idx, emitted, inflight, cyc;
        bit   prev_stall;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.in_x[i] = '0;

        repeat (2) @(negedge clk);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_y0", bus.out_y[0], 0);
        check("rst out_y3", bus.out_y[3], 0);
        check("rst out_sat", bus.out_sat, 0);
        check("rst sat_cnt", bus.sat_cnt, 0);
        rst = 1'b0;
        #1 check("rst in_ready", bus.in_ready, 1);

        send_dir("fwd_dc",  1, 1, 1, 1, 1'b0, 64, 0, 0, 0, 1'b0, 0);
        send_dir("fwd_imp", 1, 0, 0, 0, 1'b0, 16, 21, 16, 9, 1'b0, 0);
        send_dir("fwd_neg", -1, -1, -1, -1, 1'b0, -64, 0, 0, 0, 1'b0, 0);
        send_dir("inv_dc",  64, 0, 0, 0, 1'b1, 1024, 1024, 1024, 1024, 1'b0, 0);
        send_dir("inv_sat", 2047, 2047, 2047, 2047, 1'b1, 32767, -24052, 24052, 4606, 1'b1, 1);
        exp_cnt = 1;

        // Backpressure stream with out_ready pattern 1-0-0-1
        idx = 0; emitted = 0; inflight = 0; prev_stall = 1'b0; saved = '0;
        for (cyc = 0; cyc < 120 && emitted < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (idx < 8) begin
                bus.in_valid = 1'b1;
                bus.in_inv   = sinv[idx];
                for (int i = 0; i < 4; i++) bus.in_x[i] = IN_W'(sx[idx][i]);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("stall valid", bus.out_valid, 1);
                check("stall y0", bus.out_y[0], $signed(saved.y0));
                check("stall y1", bus.out_y[1], $signed(saved.y1));
                check("stall y2", bus.out_y[2], $signed(saved.y2));
                check("stall y3", bus.out_y[3], $signed(saved.y3));
                check("stall sat", bus.out_sat, saved.sat);
            end
            check("stream in_ready", bus.in_ready, !((inflight == 3) && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                check("stream no_dup", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("stream y0", bus.out_y[0], $signed(e.y0));
                    check("stream y1", bus.out_y[1], $signed(e.y1));
                    check("stream y2", bus.out_y[2], $signed(e.y2));
                    check("stream y3", bus.out_y[3], $signed(e.y3));
                    check("stream sat", bus.out_sat, e.sat);
                    if (e.sat) exp_cnt++;
                end
                emitted++;
                inflight--;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(sx[idx][0], sx[idx][1], sx[idx][2], sx[idx][3], sinv[idx]));
                idx++;
                inflight++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            saved      = {bus.out_sat, bus.out_y[0], bus.out_y[1], bus.out_y[2], bus.out_y[3]};
        end
        bus.in_valid = 1'b0;
        check("stream emitted", emitted, 8);
        check("stream accepted", idx, 8);
        @(negedge clk);
        bus.out_ready = 1'b1;
        check("stream sat_cnt", bus.sat_cnt, exp_cnt);
        check("stream drained", bus.out_valid, 0);

        // Reset with three vectors in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_inv   = 1'b1;
            for (int i = 0; i < 4; i++) bus.in_x[i] = 12'sd2047;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid in_ready full", bus.in_ready, 0);
        check("mid out_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst out_valid", bus.out_valid, 0);
        check("mid rst sat_cnt", bus.sat_cnt, 0);
        check("mid rst out_y0", bus.out_y[0], 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid no stale", bus.out_valid, 0);
        end
        check("mid sat_cnt final", bus.sat_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dct2_4_pipe.md
# dct2_4_pipe

Pipelined, parametrised 4-point DCT-II/inverse-DCT-II 1-D transform core for the VVC transform datapath. It accepts one 4-sample vector per cycle, applies the even/odd butterfly and the 64/83/36 coefficient multiplies, then rounds, shifts and saturates to a configurable output width. It uses valid/ready handshakes on both sides. It is the streaming building block for the row and column passes of the 4x4 2-D transform. A per-vector mode bit selects forward or inverse operation.

## Interface
- IN_W, 12: signed input sample width.
- OUT_W, 16: signed output sample width (saturated).
- SHIFT, 2: right shift after multiply. Rounding offset is 1<<(SHIFT-1); SHIFT=0 means no rounding and no shift.
- ACC_W, IN_W+9: internal accumulator width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  core accepts the vector this cycle.
- in_inv  in  1  0 = forward DCT-II, 1 = inverse; captured with the vector.
- in_x[0:3]  in  IN_W each  signed input samples.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts.
- out_y[0:3]  out  OUT_W each  signed results.
- out_sat  out  1  at least one lane of this vector saturated.
- sat_cnt  out  16  count of saturated vectors; sticks at 0xFFFF.

## Operation
- Forward (inv=0):
  - Butterfly: E0=x0+x3, E1=x1+x2, O0=x0-x3, O1=x1-x2 (IN_W+1 bits).
  - y0=64(E0+E1), y2=64(E0-E1), y1=83·O0+36·O1, y3=36·O0-83·O1.
- Inverse (inv=1), with the input interpreted as coefficients y0..y3:
  - E0=64(y0+y2), E1=64(y0-y2), O0=83·y1+36·y3, O1=36·y1-83·y3.
  - x0=E0+O0, x1=E1+O1, x2=E1-O1, x3=E0-O0.
  - The inverse path uses the same multiplier structure (shift-add 64/83/36 permitted), muxed by the stage-carried inv bit.
- Arithmetic: all math is signed, held in ACC_W bits, with no intermediate overflow for full-scale IN_W inputs.
- Rounding: r=(v+(1<<(SHIFT-1)))>>>SHIFT, an arithmetic shift, i.e. floor after offset.
- Saturation: r is clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]. out_sat is the OR of the four per-lane clamp flags.
- Pipeline registers:
  - S1: butterfly results.
  - S2: products and sums.
  - S3: rounded and saturated results plus the sat flag.
  - Each stage carries a valid bit and the inv bit.
- Stage flow: ready3=!v3|out_ready, ready2=!v2|ready3, ready1=!v1|ready2, in_ready=ready1.
  - A stage loads when its upstream is valid and it is ready; otherwise it holds its contents.
  - Bubbles collapse: an empty stage accepts new data even while downstream is stalled.
- sat_cnt increments on each out_valid&&out_ready handshake with out_sat=1. It saturates at 0xFFFF.

## Timing
- Latency: a vector accepted in cycle N appears on out_* in cycle N+3 when there is no stall.
- Throughput: 1 vector per cycle.
- Output stability: out_y, out_sat and out_valid hold stable while out_valid&&!out_ready.
- Stall/accept: in_ready may be 1 during a stall only while some stage is empty. A vector presented with in_valid&&!in_ready is not captured.
- Reset values: v1..v3=0, out_valid=0, out_y=0, out_sat=0, sat_cnt=0.
  - in_ready is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded and none is emitted after rst deasserts.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle with no bubble.

## Test plan
- Forward DC: x=[1,1,1,1], inv=0, SHIFT=2 -> y=[64,0,0,0] at cycle N+3, out_sat=0.
- Forward impulse: x=[1,0,0,0], inv=0 -> y=[16,21,16,9].
- Inverse DC: y=[64,0,0,0], inv=1 -> x=[1024,1024,1024,1024].
- Saturation: inv=1, input [2047,2047,2047,2047], OUT_W=16 -> out=[32767,-24052,24052,4606], out_sat=1, sat_cnt=1 after the handshake.
- Backpressure:
  - Stimulus: stream 8 random vectors with mixed inv while out_ready toggles on a 1-0-0-1 pattern.
  - Required: outputs match the golden model in order, with no loss or duplication.
  - Required: out_* stays stable while stalled, and in_ready=0 only when all three stages are valid and out_ready=0.
- Reset mid-stream: assert rst for 1 cycle with 3 vectors in flight -> out_valid=0 next cycle, no stale vector emitted, sat_cnt=0.
